// File: rtl/main_cache.sv
// main_cache: single-cycle memory-system demonstrator.
// A free-running request generator issues one byte access per clock to a
// 2-way set-associative cache (8 sets, 1-byte lines) in front of a 64-byte RAM.
// The cache is write-back by default. Define WRITE_THROUGH_EN to make every
// write also update RAM; the dirty bit is then never set and eviction never
// writes back.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - asynchronous active-high reset (counter, valid/dirty/MRU bits)
//   hit      - combinational, current request hits in either way
//   readdata - combinational, read: cache data on hit else RAM data;
//              write: the write data
//   Address  - current request address
module main_cache (
    input  logic       clk,
    input  logic       reset,
    output logic       hit,
    output logic [7:0] readdata,
    output logic [5:0] Address
);

    localparam int unsigned AW    = 6;   // RAM address width
    localparam int unsigned DW    = 8;   // data width
    localparam int unsigned CW    = 7;   // request counter width
    localparam int unsigned SETS  = 8;
    localparam int unsigned IW    = 3;   // index width
    localparam int unsigned TW    = 3;   // tag width
    localparam int unsigned EW    = 14;  // way entry width
    localparam int unsigned DEPTH = 64;

    // Way entry field positions
    localparam int unsigned V_B  = 13;
    localparam int unsigned D_B  = 12;
    localparam int unsigned M_B  = 11;
    localparam int unsigned T_LO = 8;

`ifdef WRITE_THROUGH_EN
    localparam bit WRITE_THROUGH = 1'b1;
`else
    localparam bit WRITE_THROUGH = 1'b0;
`endif

    logic [CW-1:0] cnt;
    logic          rwb;
    logic [DW-1:0] data;
    logic [IW-1:0] index;
    logic [TW-1:0] tag;

    logic [EW-1:0] way1 [0:SETS-1];
    logic [EW-1:0] way2 [0:SETS-1];

    // RAM cells power up as zero. Each cell holds its value XORed with the
    // power-up image 8'h80|a, so the visible RAM starts as mem[a] = 8'h80|a
    // without any load sequence and is untouched by reset.
    logic [DW-1:0] ram_delta [0:DEPTH-1];

    logic [EW-1:0] e1;
    logic [EW-1:0] e2;
    logic [EW-1:0] victim;
    logic [EW-1:0] acc_line;
    logic          hit1;
    logic          hit2;
    logic          victim2;
    logic          sel2;
    logic          memwriteen;
    logic          wt_write;
    logic [DW-1:0] memdata;
    logic [DW-1:0] readdata1;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;

    // Power-up RAM contents at address a
    function automatic logic [DW-1:0] ram_image(input logic [AW-1:0] a);
        return 8'h80 | DW'(a);
    endfunction

    // Request generator: address, direction and write data from the counter
    always_comb begin
        Address = {1'b0, (cnt[5:4] == 2'b11), cnt[3:0]};
        rwb     = (cnt[5:4] != 2'b01);
        data    = {2'b01, Address};
        index   = Address[2:0];
        tag     = Address[5:3];
    end

    // Lookup and read path
    always_comb begin
        e1        = way1[index];
        e2        = way2[index];
        hit1      = e1[V_B] && (e1[T_LO +: TW] == tag);
        hit2      = e2[V_B] && (e2[T_LO +: TW] == tag);
        hit       = hit1 || hit2;
        readdata1 = hit1 ? e1[DW-1:0] : e2[DW-1:0];
        memdata   = ram_delta[Address] ^ ram_image(Address);
        readdata  = rwb ? (hit ? readdata1 : memdata) : data;
    end

    // Victim choice, new line content and RAM write port
    always_comb begin
        // way1 if invalid, else way2 if invalid, else the non-MRU way
        victim2    = e1[V_B] && (!e2[V_B] || e1[M_B]);
        victim     = victim2 ? e2 : e1;
        memwriteen = !WRITE_THROUGH && !hit && victim[V_B] && victim[D_B];
        sel2       = hit ? hit2 : victim2;

        acc_line = hit2 ? e2 : e1;
        if (hit) begin
            acc_line[M_B] = 1'b1;
            if (!rwb) begin
                acc_line[DW-1:0] = data;
                acc_line[D_B]    = !WRITE_THROUGH;
            end
        end else begin
            acc_line = {1'b1, (!rwb && !WRITE_THROUGH), 1'b1, tag,
                        (rwb ? memdata : data)};
        end

        // Write-back and write-through never coincide: dirty is never set
        // when write-through is enabled.
        wt_write  = WRITE_THROUGH && !rwb;
        ram_we    = memwriteen || wt_write;
        ram_waddr = wt_write ? Address : {victim[T_LO +: TW], index};
        ram_wdata = wt_write ? data : victim[DW-1:0];
    end

    // Request counter and cache arrays; reset only clears control bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            for (int i = 0; i < SETS; i++) begin
                way1[i][V_B:M_B] <= '0;
                way2[i][V_B:M_B] <= '0;
            end
        end else begin
            cnt <= cnt + CW'(1);
            if (sel2) begin
                way2[index]      <= acc_line;
                way1[index][M_B] <= 1'b0;
            end else begin
                way1[index]      <= acc_line;
                way2[index][M_B] <= 1'b0;
            end
        end
    end

    // RAM write port; blocked while reset is held
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            ram_delta[ram_waddr] <= ram_wdata ^ ram_image(ram_waddr);
        end
    end

endmodule

// File: tb/tb_main_cache.sv
// Testbench for main_cache: directed walk through the request sequence plus
// randomly placed asynchronous resets, checked against a line-level LRU model.
module tb_main_cache;

`ifdef WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       hit;
    logic [7:0] readdata;
    logic [5:0] Address;

    main_cache dut (
        .clk      (clk),
        .reset    (reset),
        .hit      (hit),
        .readdata (readdata),
        .Address  (Address)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hits_seen = 0;

    // Reference model: RAM image plus a set of resident lines keyed by
    // address, with a last-use timestamp for LRU replacement.
    int         m_cnt;
    int         m_time;
    logic [7:0] m_ram     [64];
    bit         m_present [64];
    logic [7:0] m_data    [64];
    bit         m_dirty   [64];
    int         m_stamp   [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            m_present[i] = 1'b0;
            m_dirty[i]   = 1'b0;
        end
    endtask

    // Predict the current request's outputs, then apply its effect
    task automatic model_step(output logic [5:0] ea, output logic eh,
                              output logic [7:0] er, output logic ew);
        int         seg;
        int         a;
        int         v;
        int         n;
        logic       rd;
        logic [7:0] d;
        seg = (m_cnt / 16) % 4;
        a   = (seg == 3 ? 16 : 0) + (m_cnt % 16);
        rd  = (seg != 1);
        d   = 8'(64 + a);
        ea  = 6'(a);
        eh  = m_present[a];
        ew  = 1'b0;
        if (!rd)
            er = d;
        else if (eh)
            er = m_data[a];
        else
            er = m_ram[a];

        m_time++;
        if (!eh) begin
            n = 0;
            v = -1;
            for (int b = 0; b < 64; b++) begin
                if (b != a && (b % 8) == (a % 8) && m_present[b]) begin
                    n++;
                    if (v < 0 || m_stamp[b] < m_stamp[v]) v = b;
                end
            end
            if (n >= 2) begin
                if (m_dirty[v]) begin
                    m_ram[v] = m_data[v];
                    ew       = 1'b1;
                end
                m_present[v] = 1'b0;
            end
            m_present[a] = 1'b1;
            m_data[a]    = m_ram[a];
            m_dirty[a]   = 1'b0;
        end
        if (!rd) begin
            m_data[a] = d;
            if (WT) m_ram[a] = d;
            else    m_dirty[a] = 1'b1;
        end
        m_stamp[a] = m_time;
        m_cnt      = (m_cnt + 1) % 128;
    endtask

    // Check one request against the model and advance one clock
    task automatic step();
        logic [5:0] ea;
        logic       eh;
        logic [7:0] er;
        logic       ew;
        model_step(ea, eh, er, ew);
        chk("address",    32'(Address),         32'(ea));
        chk("hit",        32'(hit),             32'(eh));
        chk("readdata",   32'(readdata),        32'(er));
        chk("memwriteen", 32'(dut.memwriteen),  32'(ew));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst_address",   32'(Address),          32'(0));
        chk("rst_hit",       32'(hit),              32'(0));
        chk("rst_readdata",  32'(readdata),         32'(m_ram[0]));
        chk("rst_way1_5_v",  32'(dut.way1[5][13]),  32'(0));
        chk("rst_way2_5_v",  32'(dut.way2[5][13]),  32'(0));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_ram[i] = 8'(128 + i);
        m_time = 0;
        model_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state();
        chk("rst_readdata_80", 32'(readdata), 32'h80);
        @(negedge clk);
        reset = 1'b0;
        #1;

        for (int c = 0; c < 169; c++) begin
            if (c == 16) begin
                for (int i = 0; i < 8; i++)
                    chk("fill_valid_clean",
                        32'({dut.way1[i][13:12], dut.way2[i][13:12]}), 32'(4'b1010));
            end
            if (c < 16)
                chk("fill_readdata", 32'(readdata), 32'(8'h80 | 8'(c)));
            if (c == 32) begin
                chk("way1_5_data",  32'(dut.way1[5][7:0]), 32'h45);
                chk("way1_5_dirty", 32'(dut.way1[5][12]),  32'(!WT));
                chk("way2_5_data",  32'(dut.way2[5][7:0]), 32'h4D);
                chk("way2_5_dirty", 32'(dut.way2[5][12]),  32'(!WT));
            end
            if (c == 45)
                chk("read_hit_13", 32'(readdata), 32'h4D);
            if (c >= 48 && c <= 63)
                chk("evict_strobe", 32'(dut.memwriteen), 32'(!WT));
            if (c == 69) begin
                chk("wb_miss_5", 32'(hit),      32'(0));
                chk("wb_data_5", 32'(readdata), 32'h45);
            end
            if (c >= 1 && c <= 100 && hit === 1'b1)
                hits_seen++;
            if (c == 101)
                chk("hit_total", 32'(hits_seen), 32'(53));

            if (c == 168) begin
                // mid-sequence reset at cnt 40
                chk("cnt40_address", 32'(Address), 32'(40 % 16));
                #3;
                reset = 1'b1;
                model_reset();
                #1;
                check_reset_state();
                @(negedge clk);
                reset = 1'b0;
                #1;
                chk("post_reset_miss", 32'(hit), 32'(0));
                step();
            end else begin
                step();
            end
        end

        // Random run lengths with asynchronous resets at random points
        repeat (6) begin
            repeat ($urandom_range(5, 200)) step();
            #($urandom_range(1, 3));
            reset = 1'b1;
            model_reset();
            #1;
            check_reset_state();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            #1;
        end
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
